// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 keyboard receiver (device-to-host direction only).
//
// Conditions the raw PS/2 clock and data lines, frames 11-bit PS/2 words
// (start, 8 data bits LSB first, odd parity, stop) and delivers one scan code
// per good frame to the downstream note decoder. Bad frames are dropped and
// reported with a single-cycle error pulse. The keycode output never changes
// because of an error frame.
//
// Ports:
//   clk            system clock, all logic on the rising edge
//   rst            synchronous, active-high reset
//   ps2_clk        raw PS/2 clock (asynchronous, open-collector, idles high)
//   ps2_data       raw PS/2 data  (asynchronous, idles high)
//   keycode        last correctly received scan code, held until the next good frame
//   keycode_valid  one-cycle pulse in the cycle keycode updates
//   parity_err     one-cycle pulse: frame with even parity, byte discarded
//   frame_err      one-cycle pulse: bad start/stop bit or mid-frame timeout
module ps2_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       keycode_valid,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Odd parity holds when the 8 data bits plus the parity bit carry an odd
    // number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    // Synchronisers and filter state.
    logic          clk_sync1_q;
    logic          clk_sync2_q;
    logic          data_sync1_q;
    logic          data_sync2_q;
    logic [7:0]    filt_cnt_q;
    logic [7:0]    filt_cnt_d;
    logic          clk_f_q;
    logic          clk_f_d;
    logic          clk_f_prev_q;
    logic          fall_s;

    // Frame state.
    state_t        state_q;
    state_t        state_d;
    logic [2:0]    bit_cnt_q;
    logic [2:0]    bit_cnt_d;
    logic [7:0]    shift_q;
    logic [7:0]    shift_d;
    logic          parity_q;
    logic          parity_d;
    logic [TW-1:0] timeout_q;
    logic [TW-1:0] timeout_d;
    logic          timeout_hit_s;

    // Registered outputs.
    logic [7:0]    keycode_q;
    logic [7:0]    keycode_d;
    logic          keycode_valid_q;
    logic          keycode_valid_d;
    logic          parity_err_q;
    logic          parity_err_d;
    logic          frame_err_q;
    logic          frame_err_d;

    // Two-flop synchronisers for both PS/2 lines; idle-high reset values.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync1_q  <= 1'b1;
            clk_sync2_q  <= 1'b1;
            data_sync1_q <= 1'b1;
            data_sync2_q <= 1'b1;
        end else begin
            clk_sync1_q  <= ps2_clk;
            clk_sync2_q  <= clk_sync1_q;
            data_sync1_q <= ps2_data;
            data_sync2_q <= data_sync1_q;
        end
    end

    // Glitch filter: the filtered clock follows the synchronised clock only
    // once the new level has persisted for FILTER_LEN consecutive cycles.
    // Any return to the current filtered level restarts the count.
    always_comb begin
        filt_cnt_d = filt_cnt_q;
        clk_f_d    = clk_f_q;
        if (clk_sync2_q == clk_f_q) begin
            filt_cnt_d = 8'd0;
        end else if (filt_cnt_q == 8'(FILTER_LEN - 1)) begin
            filt_cnt_d = 8'd0;
            clk_f_d    = clk_sync2_q;
        end else begin
            filt_cnt_d = filt_cnt_q + 8'd1;
        end
    end

    // Filter registers and the previous filtered level for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_cnt_q   <= 8'd0;
            clk_f_q      <= 1'b1;
            clk_f_prev_q <= 1'b1;
        end else begin
            filt_cnt_q   <= filt_cnt_d;
            clk_f_q      <= clk_f_d;
            clk_f_prev_q <= clk_f_q;
        end
    end

    assign fall_s = clk_f_prev_q & ~clk_f_q;

    // Timeout fires when the counter is about to reach TIMEOUT_CYCLES, so the
    // error pulse lands exactly TIMEOUT_CYCLES clocks after the last fall.
    assign timeout_hit_s = (state_q != IDLE) && (timeout_q == TW'(TIMEOUT_CYCLES - 1));

    // Frame FSM next-state, timeout counter and output pulse logic.
    always_comb begin
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        shift_d         = shift_q;
        parity_d        = parity_q;
        keycode_d       = keycode_q;
        keycode_valid_d = 1'b0;
        parity_err_d    = 1'b0;
        frame_err_d     = 1'b0;

        if (state_q == IDLE) begin
            timeout_d = '0;
        end else if (fall_s) begin
            timeout_d = '0;
        end else begin
            timeout_d = timeout_q + TW'(1);
        end

        // A timeout in the same cycle as a fall takes precedence; the edge is lost.
        if (timeout_hit_s) begin
            state_d     = IDLE;
            bit_cnt_d   = 3'd0;
            timeout_d   = '0;
            frame_err_d = 1'b1;
        end else if (fall_s) begin
            case (state_q)
                IDLE: begin
                    if (!data_sync2_q) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                DATA: begin
                    shift_d = {data_sync2_q, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d   = PARITY;
                        bit_cnt_d = 3'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                PARITY: begin
                    parity_d = data_sync2_q;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!data_sync2_q) begin
                        frame_err_d = 1'b1;
                    end else if (!odd_parity_ok(shift_q, parity_q)) begin
                        parity_err_d = 1'b1;
                    end else begin
                        keycode_d       = shift_q;
                        keycode_valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    bit_cnt_d = 3'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Frame state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            bit_cnt_q       <= 3'd0;
            shift_q         <= 8'd0;
            parity_q        <= 1'b0;
            timeout_q       <= '0;
            keycode_q       <= 8'h00;
            keycode_valid_q <= 1'b0;
            parity_err_q    <= 1'b0;
            frame_err_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            parity_q        <= parity_d;
            timeout_q       <= timeout_d;
            keycode_q       <= keycode_d;
            keycode_valid_q <= keycode_valid_d;
            parity_err_q    <= parity_err_d;
            frame_err_q     <= frame_err_d;
        end
    end

    assign keycode       = keycode_q;
    assign keycode_valid = keycode_valid_q;
    assign parity_err    = parity_err_q;
    assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Testbench for ps2_rx: directed PS/2 frames with hand-computed expectations.
module tb_ps2_rx;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 1000;
    localparam int HALF       = 30;                 // PS/2 half period in clk cycles (scaled)
    localparam int LAT        = FILTER_LEN + 3;     // raw fall -> output pulse: 2 sync + filter + edge reg

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] keycode;
    logic       keycode_valid;
    logic       parity_err;
    logic       frame_err;

    int n_pass = 0;
    int n_checks = 0;

    int cyc = 0;
    int drop_cyc = 0;
    int valid_cnt = 0;
    int perr_cnt = 0;
    int ferr_cnt = 0;
    int valid_cyc = 0;
    int perr_cyc = 0;
    int ferr_cyc = 0;
    logic [7:0] codes [0:7];

    ps2_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .keycode      (keycode),
        .keycode_valid(keycode_valid),
        .parity_err   (parity_err),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (keycode_valid) begin
            if (valid_cnt < 8) codes[valid_cnt] = keycode;
            valid_cnt = valid_cnt + 1;
            valid_cyc = cyc;
        end
        if (parity_err) begin
            perr_cnt = perr_cnt + 1;
            perr_cyc = cyc;
        end
        if (frame_err) begin
            ferr_cnt = ferr_cnt + 1;
            ferr_cyc = cyc;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        valid_cnt = 0;
        perr_cnt  = 0;
        ferr_cnt  = 0;
    endtask

    // Sends the first nbits of an 11-bit frame; bits[0] is the start bit.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input bit glitch);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            if (glitch) begin
                wait_cyc(8);
                ps2_clk = 1'b0;
                wait_cyc(3);
                ps2_clk = 1'b1;
                if (!bits[i]) begin
                    wait_cyc(4);
                    ps2_data = 1'b1;
                    wait_cyc(3);
                    ps2_data = 1'b0;
                    wait_cyc(HALF - 18);
                end else begin
                    wait_cyc(HALF - 11);
                end
            end else begin
                wait_cyc(HALF);
            end
            ps2_clk  = 1'b0;
            drop_cyc = cyc;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_cyc(HALF);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop_bit, input bit glitch);
        send_bits({stop_bit, par, data, 1'b0}, 11, glitch);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_cyc(5);
        n_checks++; if (keycode !== 8'h00) $display("FAIL reset_keycode: got %h expected 00", keycode); else n_pass++;
        n_checks++; if (keycode_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", keycode_valid); else n_pass++;
        n_checks++; if (parity_err !== 1'b0) $display("FAIL reset_perr: got %b expected 0", parity_err); else n_pass++;
        n_checks++; if (frame_err !== 1'b0) $display("FAIL reset_ferr: got %b expected 0", frame_err); else n_pass++;
        rst = 1'b0;
        wait_cyc(5);
    endtask

    task automatic test_good_frame();
        clear_mon();
        send_frame(8'h16, 1'b0, 1'b1, 1'b0);
        n_checks++; if (valid_cnt !== 1) $display("FAIL good_valid_cnt: got %0d expected 1", valid_cnt); else n_pass++;
        n_checks++; if (keycode !== 8'h16) $display("FAIL good_keycode: got %h expected 16", keycode); else n_pass++;
        n_checks++; if (perr_cnt + ferr_cnt !== 0) $display("FAIL good_errors: got %0d expected 0", perr_cnt + ferr_cnt); else n_pass++;
        n_checks++; if (valid_cyc - drop_cyc !== LAT) $display("FAIL good_latency: got %0d expected %0d", valid_cyc - drop_cyc, LAT); else n_pass++;
    endtask

    task automatic test_back_to_back();
        clear_mon();
        send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
        send_frame(8'h1E, 1'b1, 1'b1, 1'b0);
        n_checks++; if (valid_cnt !== 2) $display("FAIL b2b_valid_cnt: got %0d expected 2", valid_cnt); else n_pass++;
        n_checks++; if (codes[0] !== 8'hF0) $display("FAIL b2b_code0: got %h expected f0", codes[0]); else n_pass++;
        n_checks++; if (codes[1] !== 8'h1E) $display("FAIL b2b_code1: got %h expected 1e", codes[1]); else n_pass++;
        n_checks++; if (perr_cnt + ferr_cnt !== 0) $display("FAIL b2b_errors: got %0d expected 0", perr_cnt + ferr_cnt); else n_pass++;
    endtask

    task automatic test_parity_err();
        clear_mon();
        send_frame(8'h26, 1'b1, 1'b1, 1'b0);
        n_checks++; if (perr_cnt !== 1) $display("FAIL perr_cnt: got %0d expected 1", perr_cnt); else n_pass++;
        n_checks++; if (valid_cnt !== 0) $display("FAIL perr_valid_cnt: got %0d expected 0", valid_cnt); else n_pass++;
        n_checks++; if (ferr_cnt !== 0) $display("FAIL perr_ferr_cnt: got %0d expected 0", ferr_cnt); else n_pass++;
        n_checks++; if (keycode !== 8'h1E) $display("FAIL perr_keycode: got %h expected 1e", keycode); else n_pass++;
        n_checks++; if (perr_cyc - drop_cyc !== LAT) $display("FAIL perr_latency: got %0d expected %0d", perr_cyc - drop_cyc, LAT); else n_pass++;
    endtask

    task automatic test_stop_err();
        clear_mon();
        send_frame(8'h16, 1'b0, 1'b0, 1'b0);
        n_checks++; if (ferr_cnt !== 1) $display("FAIL stop_ferr_cnt: got %0d expected 1", ferr_cnt); else n_pass++;
        n_checks++; if (valid_cnt + perr_cnt !== 0) $display("FAIL stop_other: got %0d expected 0", valid_cnt + perr_cnt); else n_pass++;
        n_checks++; if (keycode !== 8'h1E) $display("FAIL stop_keycode: got %h expected 1e", keycode); else n_pass++;
        clear_mon();
        send_frame(8'h26, 1'b0, 1'b1, 1'b0);
        n_checks++; if (valid_cnt !== 1) $display("FAIL stop_next_valid: got %0d expected 1", valid_cnt); else n_pass++;
        n_checks++; if (keycode !== 8'h26) $display("FAIL stop_next_keycode: got %h expected 26", keycode); else n_pass++;
    endtask

    task automatic test_timeout();
        clear_mon();
        // start + d0..d3 of 0x1E, then the line idles high
        send_bits({1'b1, 1'b1, 8'h1E, 1'b0}, 5, 1'b0);
        wait_cyc(TIMEOUT + 100);
        n_checks++; if (ferr_cnt !== 1) $display("FAIL to_ferr_cnt: got %0d expected 1", ferr_cnt); else n_pass++;
        n_checks++; if (ferr_cyc - drop_cyc !== LAT + TIMEOUT) $display("FAIL to_latency: got %0d expected %0d", ferr_cyc - drop_cyc, LAT + TIMEOUT); else n_pass++;
        n_checks++; if (valid_cnt + perr_cnt !== 0) $display("FAIL to_other: got %0d expected 0", valid_cnt + perr_cnt); else n_pass++;
        n_checks++; if (keycode !== 8'h26) $display("FAIL to_keycode: got %h expected 26", keycode); else n_pass++;
        clear_mon();
        send_frame(8'h1E, 1'b1, 1'b1, 1'b0);
        n_checks++; if (valid_cnt !== 1) $display("FAIL to_next_valid: got %0d expected 1", valid_cnt); else n_pass++;
        n_checks++; if (keycode !== 8'h1E) $display("FAIL to_next_keycode: got %h expected 1e", keycode); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        clear_mon();
        send_bits({1'b1, 1'b1, 8'h1E, 1'b0}, 5, 1'b0);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        n_checks++; if (keycode !== 8'h00) $display("FAIL rst_keycode: got %h expected 00", keycode); else n_pass++;
        wait_cyc(TIMEOUT + 100);
        n_checks++; if (ferr_cnt + perr_cnt + valid_cnt !== 0) $display("FAIL rst_pulses: got %0d expected 0", ferr_cnt + perr_cnt + valid_cnt); else n_pass++;
        send_frame(8'h16, 1'b0, 1'b1, 1'b0);
        n_checks++; if (valid_cnt !== 1) $display("FAIL rst_next_valid: got %0d expected 1", valid_cnt); else n_pass++;
        n_checks++; if (keycode !== 8'h16) $display("FAIL rst_next_keycode: got %h expected 16", keycode); else n_pass++;
    endtask

    task automatic test_glitch();
        // Start from a different keycode so a correct decode is visible.
        send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
        clear_mon();
        send_frame(8'h16, 1'b0, 1'b1, 1'b1);
        n_checks++; if (valid_cnt !== 1) $display("FAIL glitch_valid_cnt: got %0d expected 1", valid_cnt); else n_pass++;
        n_checks++; if (keycode !== 8'h16) $display("FAIL glitch_keycode: got %h expected 16", keycode); else n_pass++;
        n_checks++; if (perr_cnt + ferr_cnt !== 0) $display("FAIL glitch_errors: got %0d expected 0", perr_cnt + ferr_cnt); else n_pass++;
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_good_frame();
        test_back_to_back();
        test_parity_err();
        test_stop_err();
        test_timeout();
        test_reset_mid_frame();
        test_glitch();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
